// File: rtl/smpl_cnt_pkg.sv
// Shared types, error-bit indices and lane-matching helper for the hit-count scoreboard.
package smpl_cnt_pkg;
  localparam int MAX_LANES = 8;
  localparam int TAG_W_MAX = 32;
  localparam int CNT_W_MAX = 32;

  localparam int ERR_OVF = 0;
  localparam int ERR_DUP = 1;
  localparam int ERR_UNK = 2;
  localparam int ERR_ORD = 3;
  localparam int ERR_SAT = 4;

  // Fields are held at maximum width; instances zero-extend into them.
  typedef struct packed {
    logic                 valid;
    logic [TAG_W_MAX-1:0] tag;
    logic [CNT_W_MAX-1:0] cnt;
    logic                 sat;
  } smpl_cnt_entry_t;

  function automatic logic [3:0] lane_match_count(
    input logic [MAX_LANES-1:0]                hit_valid,
    input logic [MAX_LANES-1:0][TAG_W_MAX-1:0] hit_tags,
    input logic [TAG_W_MAX-1:0]                tag
  );
    logic [3:0] n;
    n = '0;
    for (int l = 0; l < MAX_LANES; l++) begin
      if (hit_valid[l] && (hit_tags[l] == tag)) n = n + 4'd1;
    end
    return n;
  endfunction
endpackage

// File: rtl/smpl_cnt_entry.sv
// One scoreboard slot: allocate, saturating hit accumulate, clear on retire.
module smpl_cnt_entry
  import smpl_cnt_pkg::*;
#(
  parameter int TAG_W     = 8,
  parameter int HIT_LANES = 2,
  parameter int CNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alloc,
  input  logic [TAG_W-1:0]           alloc_tag,
  input  logic                       clear,
  input  logic [HIT_LANES-1:0]       hit_valid,
  input  logic [HIT_LANES*TAG_W-1:0] hit_tag,
  output logic                       valid,
  output logic [TAG_W-1:0]           tag,
  output logic [CNT_W-1:0]           cnt_next,
  output logic                       sat_next,
  output logic                       sat_hit,
  output logic [HIT_LANES-1:0]       match
);
  localparam logic [CNT_W_MAX-1:0] CNT_MAX = CNT_W_MAX'({CNT_W{1'b1}});

  smpl_cnt_entry_t                     q_reg;
  logic [MAX_LANES-1:0]                hv_pad;
  logic [MAX_LANES-1:0][TAG_W_MAX-1:0] ht_pad;
  logic [TAG_W_MAX-1:0]                atag_pad;
  logic [3:0]                          own_n;
  logic [3:0]                          new_n;
  logic [CNT_W_MAX:0]                  sum;
  logic [CNT_W_MAX-1:0]                cnt_full_next;

  always_comb begin
    hv_pad   = '0;
    ht_pad   = '0;
    atag_pad = '0;
    atag_pad[TAG_W-1:0] = alloc_tag;
    for (int l = 0; l < HIT_LANES; l++) begin
      hv_pad[l]            = hit_valid[l];
      ht_pad[l][TAG_W-1:0] = hit_tag[l*TAG_W +: TAG_W];
    end
    own_n = q_reg.valid ? lane_match_count(hv_pad, ht_pad, q_reg.tag) : 4'd0;
    new_n = alloc ? lane_match_count(hv_pad, ht_pad, atag_pad) : 4'd0;
    sum           = {1'b0, q_reg.cnt} + (CNT_W_MAX+1)'(own_n);
    sat_hit       = sum > {1'b0, CNT_MAX};
    cnt_full_next = sat_hit ? CNT_MAX : sum[CNT_W_MAX-1:0];
  end

  // A lane is claimed by the live tag or by a tag being allocated this cycle.
  generate
    for (genvar gi = 0; gi < HIT_LANES; gi++) begin : g_match
      assign match[gi] = hit_valid[gi] &&
        ((q_reg.valid && (hit_tag[gi*TAG_W +: TAG_W] == q_reg.tag[TAG_W-1:0])) ||
         (alloc && (hit_tag[gi*TAG_W +: TAG_W] == alloc_tag)));
    end
  endgenerate

  assign valid    = q_reg.valid;
  assign tag      = q_reg.tag[TAG_W-1:0];
  assign cnt_next = cnt_full_next[CNT_W-1:0];
  assign sat_next = q_reg.sat | sat_hit;

  // Allocation wins over clear: when full, retire and refill hit the same slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg <= '0;
    end else if (alloc) begin
      q_reg.valid <= 1'b1;
      q_reg.tag   <= atag_pad;
      q_reg.cnt   <= CNT_W_MAX'(new_n);
      q_reg.sat   <= 1'b0;
    end else if (clear) begin
      q_reg <= '0;
    end else if (q_reg.valid) begin
      q_reg.cnt <= cnt_full_next;
      q_reg.sat <= q_reg.sat | sat_hit;
    end
  end
endmodule

// File: rtl/smpl_cnt_tracker.sv
// In-order hit-count scoreboard: counts tagged hits per triangle and reports pass/fail on retire.
module smpl_cnt_tracker
  import smpl_cnt_pkg::*;
#(
  parameter int TAG_W     = 8,
  parameter int DEPTH     = 4,
  parameter int HIT_LANES = 2,
  parameter int CNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tri_start_R16H,
  input  logic [TAG_W-1:0]           tri_tag_R16U,
  input  logic [HIT_LANES-1:0]       hit_valid_R18H,
  input  logic [HIT_LANES*TAG_W-1:0] hit_tag_R18U,
  input  logic                       tri_end_RnnH,
  input  logic [TAG_W-1:0]           end_tag_RnnU,
  input  logic [CNT_W-1:0]           exp_cnt_RnnU,
  output logic                       chk_valid_RnnH,
  output logic                       chk_pass_RnnH,
  output logic [TAG_W-1:0]           chk_tag_RnnU,
  output logic [CNT_W-1:0]           chk_cnt_RnnU,
  output logic [CNT_W-1:0]           chk_exp_RnnU,
  output logic [$clog2(DEPTH):0]     in_flight_RnnU,
  output logic                       full_RnnH,
  output logic [4:0]                 err_RnnU
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]     head_reg, tail_reg;
  logic [PTR_W:0]       occ_reg, occ_next;
  logic [4:0]           err_reg, err_next;
  logic                 chk_valid_reg, chk_pass_reg, full_reg;
  logic [TAG_W-1:0]     chk_tag_reg;
  logic [CNT_W-1:0]     chk_cnt_reg, chk_exp_reg;

  logic [DEPTH-1:0]     ent_valid, ent_sat_next, ent_sat_hit, ent_alloc, ent_clear;
  logic [TAG_W-1:0]     ent_tag      [DEPTH];
  logic [CNT_W-1:0]     ent_cnt_next [DEPTH];
  logic [HIT_LANES-1:0] ent_match    [DEPTH];

  logic end_ok, start_ok, is_full, dup, lane_unk;
  logic [HIT_LANES-1:0] lane_known;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign ent_alloc[gi] = start_ok && (tail_reg == PTR_W'(gi));
      assign ent_clear[gi] = end_ok && (head_reg == PTR_W'(gi));
      smpl_cnt_entry #(.TAG_W(TAG_W), .HIT_LANES(HIT_LANES), .CNT_W(CNT_W)) u_entry (
        .clk       (clk),
        .rst       (rst),
        .alloc     (ent_alloc[gi]),
        .alloc_tag (tri_tag_R16U),
        .clear     (ent_clear[gi]),
        .hit_valid (hit_valid_R18H),
        .hit_tag   (hit_tag_R18U),
        .valid     (ent_valid[gi]),
        .tag       (ent_tag[gi]),
        .cnt_next  (ent_cnt_next[gi]),
        .sat_next  (ent_sat_next[gi]),
        .sat_hit   (ent_sat_hit[gi]),
        .match     (ent_match[gi])
      );
    end
  endgenerate

  always_comb begin
    end_ok     = tri_end_RnnH && ent_valid[head_reg] && (ent_tag[head_reg] == end_tag_RnnU);
    is_full    = (occ_reg == (PTR_W+1)'(DEPTH)) && !end_ok;
    dup        = 1'b0;
    lane_known = '0;
    // The head being retired this cycle no longer counts as holding its tag.
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (ent_tag[i] == tri_tag_R16U) && !(end_ok && (head_reg == PTR_W'(i))))
        dup = 1'b1;
      lane_known = lane_known | ent_match[i];
    end
    start_ok = tri_start_R16H && !is_full && !dup;
    lane_unk = |(hit_valid_R18H & ~lane_known);
    occ_next = occ_reg + (PTR_W+1)'(start_ok) - (PTR_W+1)'(end_ok);

    err_next          = err_reg;
    err_next[ERR_OVF] = err_reg[ERR_OVF] | (tri_start_R16H && is_full);
    err_next[ERR_DUP] = err_reg[ERR_DUP] | (tri_start_R16H && !is_full && dup);
    err_next[ERR_UNK] = err_reg[ERR_UNK] | lane_unk;
    err_next[ERR_ORD] = err_reg[ERR_ORD] | (tri_end_RnnH && !end_ok);
    err_next[ERR_SAT] = err_reg[ERR_SAT] | (|ent_sat_hit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg      <= '0;
      tail_reg      <= '0;
      occ_reg       <= '0;
      full_reg      <= 1'b0;
      err_reg       <= '0;
      chk_valid_reg <= 1'b0;
      chk_pass_reg  <= 1'b0;
      chk_tag_reg   <= '0;
      chk_cnt_reg   <= '0;
      chk_exp_reg   <= '0;
    end else begin
      head_reg      <= head_reg + PTR_W'(end_ok);
      tail_reg      <= tail_reg + PTR_W'(start_ok);
      occ_reg       <= occ_next;
      full_reg      <= (occ_next == (PTR_W+1)'(DEPTH));
      err_reg       <= err_next;
      chk_valid_reg <= end_ok;
      if (end_ok) begin
        chk_tag_reg  <= end_tag_RnnU;
        chk_cnt_reg  <= ent_cnt_next[head_reg];
        chk_exp_reg  <= exp_cnt_RnnU;
        chk_pass_reg <= (ent_cnt_next[head_reg] == exp_cnt_RnnU) && !ent_sat_next[head_reg];
      end
    end
  end

  assign chk_valid_RnnH = chk_valid_reg;
  assign chk_pass_RnnH  = chk_pass_reg;
  assign chk_tag_RnnU   = chk_tag_reg;
  assign chk_cnt_RnnU   = chk_cnt_reg;
  assign chk_exp_RnnU   = chk_exp_reg;
  assign in_flight_RnnU = occ_reg;
  assign full_RnnH      = full_reg;
  assign err_RnnU       = err_reg;
endmodule

// File: tb/tb_smpl_cnt_tracker.sv
// Directed bench for smpl_cnt_tracker (DEPTH=4, two lanes, 4-bit counters for saturation).
module tb_smpl_cnt_tracker;
  logic        clk;
  logic        rst;
  logic        tri_start;
  logic [7:0]  tri_tag;
  logic [1:0]  hit_valid;
  logic [15:0] hit_tag;
  logic        tri_end;
  logic [7:0]  end_tag;
  logic [3:0]  exp_cnt;
  logic        chk_valid, chk_pass, full;
  logic [7:0]  chk_tag;
  logic [3:0]  chk_cnt, chk_exp;
  logic [2:0]  in_flight;
  logic [4:0]  err;

  int checks = 0;
  int errors = 0;

  smpl_cnt_tracker #(.TAG_W(8), .DEPTH(4), .HIT_LANES(2), .CNT_W(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .tri_start_R16H (tri_start),
    .tri_tag_R16U   (tri_tag),
    .hit_valid_R18H (hit_valid),
    .hit_tag_R18U   (hit_tag),
    .tri_end_RnnH   (tri_end),
    .end_tag_RnnU   (end_tag),
    .exp_cnt_RnnU   (exp_cnt),
    .chk_valid_RnnH (chk_valid),
    .chk_pass_RnnH  (chk_pass),
    .chk_tag_RnnU   (chk_tag),
    .chk_cnt_RnnU   (chk_cnt),
    .chk_exp_RnnU   (chk_exp),
    .in_flight_RnnU (in_flight),
    .full_RnnH      (full),
    .err_RnnU       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of stimulus; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input logic s, input logic [7:0] st, input logic [1:0] hv,
                     input logic [7:0] h0, input logic [7:0] h1,
                     input logic e, input logic [7:0] et, input logic [3:0] ex);
    tri_start = s; tri_tag = st; hit_valid = hv; hit_tag = {h1, h0};
    tri_end = e; end_tag = et; exp_cnt = ex;
    @(posedge clk); #1;
    tri_start = 1'b0; hit_valid = 2'b00; tri_end = 1'b0;
    if (chk_valid)
      $display("chk tag=%02h cnt=%0d exp=%0d pass=%0d in_flight=%0d err=%05b",
               chk_tag, chk_cnt, chk_exp, chk_pass, in_flight, err);
  endtask

  task automatic idle();
    cyc(0, 8'h00, 2'b00, 8'h00, 8'h00, 0, 8'h00, 4'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; idle(); rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); idle(); rst = 1'b0;
    checks++; if ({chk_valid, chk_pass, chk_tag, chk_cnt, chk_exp} !== 18'd0) begin
      errors++; $display("FAIL reset_chk got=%05h want=0", {chk_valid, chk_pass, chk_tag, chk_cnt, chk_exp}); end
    checks++; if ({in_flight, full, err} !== 9'd0) begin
      errors++; $display("FAIL reset_status got=%03h want=0", {in_flight, full, err}); end
  endtask

  task automatic test_single();
    do_reset();
    cyc(1, 8'h11, 2'b00, 8'h00, 8'h00, 0, 8'h00, 4'd0);
    checks++; if (in_flight !== 3'd1) begin errors++; $display("FAIL single_inflight got=%0d want=1", in_flight); end
    for (int i = 0; i < 3; i++) cyc(0, 8'h00, 2'b11, 8'h11, 8'h11, 0, 8'h00, 4'd0);
    checks++; if (chk_valid !== 1'b0) begin errors++; $display("FAIL single_early got=%0b want=0", chk_valid); end
    cyc(0, 8'h00, 2'b00, 8'h00, 8'h00, 1, 8'h11, 4'd6);
    checks++; if ({chk_valid, chk_pass, chk_tag, chk_cnt, chk_exp} !== {1'b1, 1'b1, 8'h11, 4'd6, 4'd6}) begin
      errors++; $display("FAIL single_chk got=%0b/%0b/%02h/%0d/%0d want=1/1/11/6/6", chk_valid, chk_pass, chk_tag, chk_cnt, chk_exp); end
    checks++; if ({in_flight, err} !== 8'd0) begin errors++; $display("FAIL single_status got=%0d/%05b want=0/0", in_flight, err); end
    idle();
    checks++; if (chk_valid !== 1'b0) begin errors++; $display("FAIL single_pulse got=%0b want=0", chk_valid); end
  endtask

  task automatic test_interleaved();
    do_reset();
    cyc(1, 8'h01, 2'b00, 8'h00, 8'h00, 0, 8'h00, 4'd0);
    cyc(1, 8'h02, 2'b00, 8'h00, 8'h00, 0, 8'h00, 4'd0);
    checks++; if (in_flight !== 3'd2) begin errors++; $display("FAIL inter_inflight2 got=%0d want=2", in_flight); end
    cyc(0, 8'h00, 2'b11, 8'h01, 8'h01, 0, 8'h00, 4'd0);
    cyc(0, 8'h00, 2'b11, 8'h02, 8'h01, 0, 8'h00, 4'd0);
    cyc(0, 8'h00, 2'b11, 8'h01, 8'h02, 0, 8'h00, 4'd0);
    cyc(0, 8'h00, 2'b00, 8'h00, 8'h00, 1, 8'h01, 4'd4);
    checks++; if ({chk_valid, chk_pass, chk_cnt, in_flight} !== {1'b1, 1'b1, 4'd4, 3'd1}) begin
      errors++; $display("FAIL inter_first got=%0b/%0b/%0d/%0d want=1/1/4/1", chk_valid, chk_pass, chk_cnt, in_flight); end
    cyc(0, 8'h00, 2'b00, 8'h00, 8'h00, 1, 8'h02, 4'd3);
    checks++; if ({chk_valid, chk_pass, chk_tag, chk_cnt, chk_exp, in_flight} !== {1'b1, 1'b0, 8'h02, 4'd2, 4'd3, 3'd0}) begin
      errors++; $display("FAIL inter_second got=%0b/%0b/%02h/%0d/%0d/%0d want=1/0/02/2/3/0", chk_valid, chk_pass, chk_tag, chk_cnt, chk_exp, in_flight); end
    checks++; if (err !== 5'd0) begin errors++; $display("FAIL inter_err got=%05b want=00000", err); end
  endtask

  task automatic test_full();
    logic [7:0] tags [4];
    tags = '{8'h22, 8'h23, 8'h24, 8'h26};
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, 8'h21 + 8'(i), 2'b00, 8'h00, 8'h00, 0, 8'h00, 4'd0);
    checks++; if ({full, in_flight, err} !== {1'b1, 3'd4, 5'd0}) begin
      errors++; $display("FAIL full_four got=%0b/%0d/%05b want=1/4/00000", full, in_flight, err); end
    cyc(1, 8'h25, 2'b00, 8'h00, 8'h00, 0, 8'h00, 4'd0);
    checks++; if ({in_flight, err} !== {3'd4, 5'b00001}) begin
      errors++; $display("FAIL full_ovf got=%0d/%05b want=4/00001", in_flight, err); end
    cyc(1, 8'h26, 2'b00, 8'h00, 8'h00, 1, 8'h21, 4'd0);
    checks++; if ({chk_valid, chk_pass, full, in_flight, err} !== {1'b1, 1'b1, 1'b1, 3'd4, 5'b00001}) begin
      errors++; $display("FAIL full_swap got=%0b/%0b/%0b/%0d/%05b want=1/1/1/4/00001", chk_valid, chk_pass, full, in_flight, err); end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 8'h00, 2'b00, 8'h00, 8'h00, 1, tags[i], 4'd0);
      checks++; if ({chk_valid, chk_tag, in_flight} !== {1'b1, tags[i], 3'(3 - i)}) begin
        errors++; $display("FAIL full_drain%0d got=%0b/%02h/%0d want=1/%02h/%0d", i, chk_valid, chk_tag, in_flight, tags[i], 3 - i); end
    end
    checks++; if ({full, err} !== {1'b0, 5'b00001}) begin errors++; $display("FAIL full_end got=%0b/%05b want=0/00001", full, err); end
  endtask

  task automatic test_order_unknown();
    do_reset();
    cyc(1, 8'h03, 2'b00, 8'h00, 8'h00, 0, 8'h00, 4'd0);
    cyc(0, 8'h00, 2'b00, 8'h00, 8'h00, 1, 8'h05, 4'd0);
    checks++; if ({chk_valid, in_flight, err} !== {1'b0, 3'd1, 5'b01000}) begin
      errors++; $display("FAIL order got=%0b/%0d/%05b want=0/1/01000", chk_valid, in_flight, err); end
    cyc(0, 8'h00, 2'b11, 8'h7F, 8'h03, 0, 8'h00, 4'd0);
    checks++; if (err !== 5'b01100) begin errors++; $display("FAIL unknown got=%05b want=01100", err); end
    cyc(0, 8'h00, 2'b00, 8'h00, 8'h00, 1, 8'h03, 4'd1);
    checks++; if ({chk_valid, chk_pass, chk_cnt} !== {1'b1, 1'b1, 4'd1}) begin
      errors++; $display("FAIL unknown_notcounted got=%0b/%0b/%0d want=1/1/1", chk_valid, chk_pass, chk_cnt); end
    cyc(1, 8'h08, 2'b00, 8'h00, 8'h00, 0, 8'h00, 4'd0);
    cyc(1, 8'h08, 2'b00, 8'h00, 8'h00, 0, 8'h00, 4'd0);
    checks++; if ({in_flight, err} !== {3'd1, 5'b01110}) begin
      errors++; $display("FAIL dup got=%0d/%05b want=1/01110", in_flight, err); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    cyc(1, 8'h30, 2'b11, 8'h30, 8'h30, 0, 8'h00, 4'd0);
    checks++; if ({in_flight, err} !== {3'd1, 5'd0}) begin
      errors++; $display("FAIL b2b_start got=%0d/%05b want=1/00000", in_flight, err); end
    cyc(1, 8'h31, 2'b01, 8'h30, 8'h00, 1, 8'h30, 4'd3);
    checks++; if ({chk_valid, chk_pass, chk_cnt, in_flight} !== {1'b1, 1'b1, 4'd3, 3'd1}) begin
      errors++; $display("FAIL b2b_end got=%0b/%0b/%0d/%0d want=1/1/3/1", chk_valid, chk_pass, chk_cnt, in_flight); end
  endtask

  task automatic test_saturation();
    do_reset();
    cyc(1, 8'h40, 2'b00, 8'h00, 8'h00, 0, 8'h00, 4'd0);
    for (int i = 0; i < 8; i++) cyc(0, 8'h00, 2'b11, 8'h40, 8'h40, 0, 8'h00, 4'd0);
    checks++; if (err !== 5'b10000) begin errors++; $display("FAIL sat_err got=%05b want=10000", err); end
    cyc(0, 8'h00, 2'b00, 8'h00, 8'h00, 1, 8'h40, 4'd0);
    checks++; if ({chk_valid, chk_pass, chk_cnt, chk_exp} !== {1'b1, 1'b0, 4'd15, 4'd0}) begin
      errors++; $display("FAIL sat_chk got=%0b/%0b/%0d/%0d want=1/0/15/0", chk_valid, chk_pass, chk_cnt, chk_exp); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    cyc(1, 8'h50, 2'b00, 8'h00, 8'h00, 0, 8'h00, 4'd0);
    cyc(1, 8'h51, 2'b11, 8'h50, 8'h51, 0, 8'h00, 4'd0);
    cyc(0, 8'h00, 2'b00, 8'h00, 8'h00, 1, 8'h50, 4'd1);
    checks++; if ({chk_valid, in_flight} !== {1'b1, 3'd1}) begin
      errors++; $display("FAIL midrst_pre got=%0b/%0d want=1/1", chk_valid, in_flight); end
    cyc(1, 8'h52, 2'b00, 8'h00, 8'h00, 0, 8'h00, 4'd0);
    rst = 1'b1; idle(); rst = 1'b0;
    checks++; if ({chk_valid, chk_pass, chk_tag, chk_cnt, chk_exp, in_flight, full, err} !== 27'd0) begin
      errors++; $display("FAIL midrst_clear got=%07h want=0", {chk_valid, chk_pass, chk_tag, chk_cnt, chk_exp, in_flight, full, err}); end
    cyc(0, 8'h00, 2'b10, 8'h00, 8'h51, 0, 8'h00, 4'd0);
    checks++; if ({in_flight, err} !== {3'd0, 5'b00100}) begin
      errors++; $display("FAIL midrst_unk got=%0d/%05b want=0/00100", in_flight, err); end
  endtask

  initial begin
    rst = 1'b1; tri_start = 1'b0; tri_tag = '0; hit_valid = '0; hit_tag = '0;
    tri_end = 1'b0; end_tag = '0; exp_cnt = '0;
    test_reset();
    test_single();
    test_interleaved();
    test_full();
    test_order_unknown();
    test_back_to_back();
    test_saturation();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
